// File: rtl/lc3b_l1_writeback_buffer.sv
// Single-entry write buffer between L1 memory port and L2; optional WBUF_READ_FWD_EN forwards read hits.
// Latency: write/forward hit responds the cycle after the request edge; misses add L2 latency.
// Backpressure: L1 requests are held until l1_resp; L2 requests are held until l2_resp.
module lc3b_l1_writeback_buffer #(
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 128,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l1_read,
    input  logic              l1_write,
    input  logic [ADDR_W-1:0] l1_address,
    input  logic [LINE_W-1:0] l1_wdata,
    output logic [LINE_W-1:0] l1_rdata,
    output logic              l1_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);
    localparam int TAG_W = ADDR_W - OFFSET_W;
`ifdef WBUF_READ_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, L2_RD, DRAIN, RESP} state_t;

    state_t             state, state_nxt;
    logic               buf_valid;
    logic [TAG_W-1:0]   buf_tag;
    logic [LINE_W-1:0]  buf_data;
    logic [TAG_W-1:0]   req_tag;
    logic [TAG_W-1:0]   l1_tag;
    logic               tag_hit;
    logic               offset_unused;

    assign l1_tag        = l1_address[ADDR_W-1:OFFSET_W];
    assign offset_unused = ^l1_address[OFFSET_W-1:0];
    assign tag_hit       = buf_valid && (l1_tag == buf_tag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A conflicting write or an unforwarded read hit drains first; the held
    // request is then re-evaluated in IDLE against the now-empty buffer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (l1_write) begin
                    state_nxt = (!buf_valid || tag_hit) ? RESP : DRAIN;
                end else if (l1_read) begin
                    if (tag_hit) begin
                        state_nxt = FWD_EN ? RESP : DRAIN;
                    end else begin
                        state_nxt = L2_RD;
                    end
                end else if (buf_valid) begin
                    state_nxt = DRAIN;
                end
            end
            L2_RD:   if (l2_resp) state_nxt = RESP;
            DRAIN:   if (l2_resp) state_nxt = IDLE;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            req_tag   <= '0;
            l1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_tag <= l1_tag;
                    if (l1_write && (!buf_valid || tag_hit)) begin
                        buf_valid <= 1'b1;
                        buf_tag   <= l1_tag;
                        buf_data  <= l1_wdata;
                    end else if (!l1_write && l1_read && FWD_EN && tag_hit) begin
                        l1_rdata <= buf_data;
                    end
                end
                L2_RD: if (l2_resp) l1_rdata <= l2_rdata;
                DRAIN: if (l2_resp) buf_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        l1_resp    = (state == RESP);
        l2_read    = (state == L2_RD);
        l2_write   = (state == DRAIN);
        l2_address = '0;
        l2_wdata   = '0;
        if (state == L2_RD) begin
            l2_address = {req_tag, {OFFSET_W{1'b0}}};
        end else if (state == DRAIN) begin
            l2_address = {buf_tag, {OFFSET_W{1'b0}}};
            l2_wdata   = buf_data;
        end
    end

    a_l1_excl: assert property (@(posedge clk) disable iff (!rst_n) !(l1_read && l1_write));

endmodule

// File: tb/tb_lc3b_l1_writeback_buffer.sv
// Scoreboard bench: stimulus pushes expected L1/L2 transactions, a negedge monitor pops and compares.
module tb_lc3b_l1_writeback_buffer;
    logic         clk;
    logic         rst_n;
    logic         l1_read, l1_write;
    logic [15:0]  l1_address;
    logic [127:0] l1_wdata, l1_rdata;
    logic         l1_resp;
    logic         l2_read, l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata, l2_rdata;
    logic         l2_resp;

    lc3b_l1_writeback_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .l1_read(l1_read), .l1_write(l1_write), .l1_address(l1_address),
        .l1_wdata(l1_wdata), .l1_rdata(l1_rdata), .l1_resp(l1_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    typedef struct { bit wr; logic [15:0] addr; logic [127:0] data; } l2_exp_t;
    typedef struct { bit rd; logic [127:0] data; int lat; } l1_exp_t;

    l2_exp_t l2_q[$];
    l1_exp_t l1_q[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int issue_cyc = 0;

    localparam logic [127:0] LA = {4{32'hA0A0_0001}};
    localparam logic [127:0] LB = {4{32'hB0B0_0002}};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // L2 model: responds 3 cycles after a request appears; read data is the address replicated.
    initial begin
        int cnt;
        cnt = 0;
        l2_resp = 1'b0;
        l2_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (l2_resp) begin
                l2_resp = 1'b0;
                cnt = 0;
            end else if (rst_n && (l2_read || l2_write)) begin
                cnt++;
                if (cnt == 3) begin
                    l2_resp = 1'b1;
                    l2_rdata = {8{l2_address}};
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (l2_read && l2_write) fail_now("l2_rd_wr_overlap");
            if (l2_resp && (l2_read || l2_write)) begin
                if (l2_q.size() == 0) begin
                    fail_now("l2_unexpected");
                end else begin
                    l2_exp_t e;
                    e = l2_q.pop_front();
                    check("l2_kind", {127'd0, l2_write}, {127'd0, e.wr});
                    check("l2_addr", {112'd0, l2_address}, {112'd0, e.addr});
                    if (e.wr) check("l2_wdata", l2_wdata, e.data);
                end
            end
            if (l1_resp) begin
                if (l1_q.size() == 0) begin
                    fail_now("l1_unexpected");
                end else begin
                    l1_exp_t e;
                    e = l1_q.pop_front();
                    if (e.rd) check("l1_rdata", l1_rdata, e.data);
                    if (e.lat >= 0) check("l1_latency", 128'(cyc - issue_cyc), 128'(e.lat));
                end
            end
        end
    end

    function automatic l2_exp_t mk2(input bit wr, input logic [15:0] a, input logic [127:0] d);
        l2_exp_t e;
        e.wr = wr; e.addr = a; e.data = d;
        return e;
    endfunction

    function automatic l1_exp_t mk1(input bit rd, input logic [127:0] d, input int lat);
        l1_exp_t e;
        e.rd = rd; e.data = d; e.lat = lat;
        return e;
    endfunction

    // Called aligned at posedge+1; returns aligned at posedge+1 with the request dropped.
    task automatic l1_req(input bit wr, input logic [15:0] a, input logic [127:0] d);
        bit seen;
        seen = 1'b0;
        l1_write = wr;
        l1_read = !wr;
        l1_address = a;
        l1_wdata = d;
        issue_cyc = cyc;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (l1_resp) seen = 1'b1;
        end
        if (!seen) fail_now("l1_timeout");
        @(posedge clk);
        #1;
        l1_write = 1'b0;
        l1_read = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && l2_q.size() != 0; i++) @(negedge clk);
        check("l2_q_drained", 128'(l2_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        l1_read = 1'b0;
        l1_write = 1'b0;
        l1_address = '0;
        l1_wdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_l1_resp", {127'd0, l1_resp}, 128'd0);
        check("rst_l1_rdata", l1_rdata, 128'd0);
        check("rst_l2_read", {127'd0, l2_read}, 128'd0);
        check("rst_l2_write", {127'd0, l2_write}, 128'd0);
        check("rst_l2_address", {112'd0, l2_address}, 128'd0);
        check("rst_l2_wdata", l2_wdata, 128'd0);
        check("rst_buf_valid", {127'd0, dut.buf_valid}, 128'd0);
        rst_n = 1'b1;
        idle(1);

        // 1: fast write ack, background drain, buffer empties
        l1_q.push_back(mk1(1'b0, '0, 1));
        l2_q.push_back(mk2(1'b1, 16'h1230, LA));
        l1_req(1'b1, 16'h1230, LA);
        wait_drain();
        check("t1_buf_valid", {127'd0, dut.buf_valid}, 128'd0);

        // 2: read of the buffered line
        l1_q.push_back(mk1(1'b0, '0, 1));
`ifdef WBUF_READ_FWD_EN
        l1_q.push_back(mk1(1'b1, LA, 1));
        l2_q.push_back(mk2(1'b1, 16'h1230, LA));
`else
        l2_q.push_back(mk2(1'b1, 16'h1230, LA));
        l2_q.push_back(mk2(1'b0, 16'h1230, '0));
        l1_q.push_back(mk1(1'b1, {8{16'h1230}}, -1));
`endif
        l1_req(1'b1, 16'h1230, LA);
        l1_req(1'b0, 16'h123E, '0);
        wait_drain();

        // 3: read miss to another line passes the buffered write
        l1_q.push_back(mk1(1'b0, '0, 1));
        l2_q.push_back(mk2(1'b0, 16'h4560, '0));
        l2_q.push_back(mk2(1'b1, 16'h1230, LA));
        l1_q.push_back(mk1(1'b1, {8{16'h4560}}, -1));
        l1_req(1'b1, 16'h1230, LA);
        l1_req(1'b0, 16'h4560, '0);
        wait_drain();

        // 4: conflicting write drains A first, then B is captured and drains
        l1_q.push_back(mk1(1'b0, '0, 1));
        l1_q.push_back(mk1(1'b0, '0, -1));
        l2_q.push_back(mk2(1'b1, 16'h1230, LA));
        l2_q.push_back(mk2(1'b1, 16'h8000, LB));
        l1_req(1'b1, 16'h1230, LA);
        l1_req(1'b1, 16'h8000, LB);
        wait_drain();

        // 5: same-line writes coalesce into one drain carrying B
        l1_q.push_back(mk1(1'b0, '0, 1));
        l1_q.push_back(mk1(1'b0, '0, 1));
        l2_q.push_back(mk2(1'b1, 16'h1230, LB));
        l1_req(1'b1, 16'h1230, LA);
        l1_req(1'b1, 16'h1238, LB);
        wait_drain();
        idle(10);

        // 6: reset in the middle of a drain abandons it
        l1_q.push_back(mk1(1'b0, '0, 1));
        l1_req(1'b1, 16'h1230, LA);
        for (int i = 0; i < 20 && !l2_write; i++) @(negedge clk);
        check("t6_drain_started", {127'd0, l2_write}, 128'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_l2_write", {127'd0, l2_write}, 128'd0);
        check("t6_l2_read", {127'd0, l2_read}, 128'd0);
        check("t6_l2_address", {112'd0, l2_address}, 128'd0);
        check("t6_l2_wdata", l2_wdata, 128'd0);
        check("t6_l1_resp", {127'd0, l1_resp}, 128'd0);
        check("t6_l1_rdata", l1_rdata, 128'd0);
        check("t6_buf_valid", {127'd0, dut.buf_valid}, 128'd0);
        rst_n = 1'b1;
        idle(10);

        check("end_l1_q_empty", 128'(l1_q.size()), 128'd0);
        check("end_l2_q_empty", 128'(l2_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
